hs4_rx_sync: RTL and testbench
==============================

// Module: hs4_rx_sync
// PURPOSE
//  Clocked responder for the 4-phase return-to-zero bundled-data handshake driven by C-element pipelines.
//  Synchronises req, captures din into a small FIFO, returns ack, presents tokens on a valid/pop port.
//  Sits at the async-to-sync boundary, directly after the last C-element latch stage.
// PARAMETERS
//  DW     8   data width of din/dout
//  DEPTH  4   FIFO entries, power of 2, >=2
//  AW     2   log2(DEPTH), address width
// PORTS
//  cp     in   1      clock, all state updates on rising edge
//  cdn    in   1      reset, synchronous, active-low
//  req    in   1      async request from initiator (4-phase)
//  din    in   DW     bundled data; stable from before req rise until ack rise
//  ack    out  1      acknowledge to initiator, registered
//  dout   out  DW     FIFO head
//  dvalid out  1      FIFO non-empty
//  pop    in   1      consumer takes head this edge (ignored when dvalid=0)
//  count  out  AW+1   FIFO occupancy 0..DEPTH
// BEHAVIOUR
//  Reset (cdn=0 at edge): ack=0, dvalid=0, count=0, dout=0, sync flops=0, FIFO pointers=0, state=SETTLE.
//  req_s = req after NSYNC flops (NSYNC=2, or 3 with HS4_SYNC3_EN); only req_s feeds the FSM.
//  FSM (3 states):
//   SETTLE: counts NSYNC cycles so the sync chain holds true req; then req_s=1 -> ACK (no capture,
//           stale token from a pre-reset handshake), req_s=0 -> IDLE.
//   IDLE:   req_s=1 and !full -> write din to FIFO, ack<=1, -> ACK. req_s=1 and full -> stay, ack=0 (backpressure).
//   ACK:    ack held 1; req_s=0 -> ack<=0, -> IDLE.
//  din sampled unsynchronised at the capture edge; safe because req_s lags req by >=NSYNC cycles.
//  Latency: req rise -> ack rise = NSYNC+1 edges (FIFO not full); req fall -> ack fall = NSYNC+1 edges.
//  full = (count==DEPTH), registered; a pop in the same cycle does NOT free space for that cycle's write.
//  Simultaneous write and pop: count unchanged, pointers both advance; order strictly FIFO.
//  pop with dvalid=0: no effect. Pointers wrap modulo DEPTH; count never exceeds DEPTH or underflows.
//  dout = mem[rd_ptr] when dvalid=1, else 0.
//  Reset mid-handshake: ack drops to 0 at that edge, FIFO flushed; the token in flight is not captured.
//  Initiator must see ack fall before issuing the next req (protocol).
// CONFIGURATION
//  HS4_SYNC3_EN defined: 3-flop req synchroniser, NSYNC=3, latency 4 edges each phase.
//  HS4_SYNC3_EN undefined: 2-flop synchroniser, NSYNC=2, latency 3 edges each phase.
// STRUCTURE
//  Shared package hs4_pkg: FSM state encodings (SETTLE=2'd0, IDLE=2'd1, ACK=2'd2),
//   NSYNC constant selected by HS4_SYNC3_EN, shared by the matching transmitter.
//  Sub-module hs4_sync: NSYNC-deep reset-to-0 flop chain (cp, cdn, d, q), reused on the tx side for ack.
//  FIFO and FSM inline in hs4_rx_sync.
// TESTING
//  1 Single token: DW=8, din=8'hA5, raise req -> ack=1 after 3 edges, dvalid=1, dout=8'hA5, count=1;
//    drop req -> ack=0 after 3 edges.
//  2 Backpressure: DEPTH=4, 4 tokens, no pop -> count=4; 5th req -> ack stays 0 for 20 cycles;
//    pop once -> ack rises 1 edge after count=3, count returns to 4.
//  3 Pop during capture at count=2 -> count stays 2, dout advances to next token in order.
//  4 Reset mid-handshake with req held 1 -> ack=0, count=0, dvalid=0 at reset edge; no capture
//    on release; req low then high with din=8'h3C -> dout=8'h3C, count=1.
//  5 HS4_SYNC3_EN defined: repeat test 1 -> ack rise/fall each 4 edges after req edge.
//  6 Stress: 64 tokens 0..63, random req delays and random pop -> dout sequence 0..63, no loss, no duplicate.

Source files
------------

// File: rtl/hs4_pkg.sv
// ============================================================================
//  Module      : hs4_pkg
//  Description : Shared definitions for the 4-phase bundled-data handshake
//                receiver/transmitter pair: FSM state encoding and the
//                synchroniser depth.
//  Config      : HS4_SYNC3_EN selects a 3-flop synchroniser (default 2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hs4_pkg;

`ifdef HS4_SYNC3_EN
    localparam int NSYNC = 3;
`else
    localparam int NSYNC = 2;
`endif

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACK    = 2'd2
    } hs4_state_t;

endpackage

`default_nettype wire

// File: rtl/hs4_sync.sv
// ============================================================================
//  Module      : hs4_sync
//  Description : N-deep reset-to-0 flop chain used to bring an asynchronous
//                handshake line (req on rx, ack on tx) into the clock domain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs4_sync #(
    parameter int N = 2
) (
    input  logic cp,
    input  logic cdn,
    input  logic d,
    output logic q
);

    logic [N-1:0] r_chain;

    // Shift the async input through the chain; reset clears every stage
    always_ff @(posedge cp) begin
        if (!cdn) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[N-2:0], d};
        end
    end

    assign q = r_chain[N-1];

endmodule

`default_nettype wire

// File: rtl/hs4_rx_sync.sv
// ============================================================================
//  Module      : hs4_rx_sync
//  Description : Clocked responder for a 4-phase return-to-zero bundled-data
//                handshake. Synchronises req, captures din into a small FIFO,
//                returns ack and presents tokens on a valid/pop port.
//  Config      : HS4_SYNC3_EN (via hs4_pkg) selects a 3-flop req synchroniser.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs4_rx_sync
    import hs4_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          cp,
    input  logic          cdn,
    input  logic          req,
    input  logic [DW-1:0] din,
    output logic          ack,
    output logic [DW-1:0] dout,
    output logic          dvalid,
    input  logic          pop,
    output logic [AW:0]   count
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [1:0]  C_NSYNC = 2'(NSYNC);

    logic          w_req_s;
    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_rd;

    hs4_state_t    r_state;
    logic [1:0]    r_settle;
    logic          r_ack;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    hs4_sync #(.N(NSYNC)) u_req_sync (
        .cp  (cp),
        .cdn (cdn),
        .d   (req),
        .q   (w_req_s)
    );

    // full uses the registered count only: a pop this cycle cannot make room
    // for a write in the same cycle.
    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_wr    = (r_state == ST_IDLE) && w_req_s && !w_full;
    assign w_rd    = pop && !w_empty;

    // Handshake FSM: settle after reset, capture on req, hold ack until req drops
    always_ff @(posedge cp) begin
        if (!cdn) begin
            r_state  <= ST_SETTLE;
            r_settle <= '0;
            r_ack    <= 1'b0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    // A req already high here belongs to a handshake begun
                    // before reset: acknowledge it without capturing din.
                    if (r_settle == C_NSYNC) begin
                        r_state <= w_req_s ? ST_ACK : ST_IDLE;
                        r_ack   <= w_req_s;
                    end else begin
                        r_settle <= r_settle + 2'd1;
                    end
                end
                ST_IDLE: begin
                    if (w_wr) begin
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!w_req_s) begin
                        r_ack   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state  <= ST_SETTLE;
                    r_settle <= '0;
                    r_ack    <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge cp) begin
        if (!cdn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: din is sampled directly, it has been stable for NSYNC cycles
    always_ff @(posedge cp) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign ack    = r_ack;
    assign dvalid = !w_empty;
    assign count  = r_count;
    assign dout   = dvalid ? r_mem[r_rd_ptr] : '0;

endmodule

`default_nettype wire

// File: tb/tb_hs4_rx_sync.sv
// ============================================================================
//  Module      : tb_hs4_rx_sync
//  Description : Self-checking bench for hs4_rx_sync. A behavioural model
//                (req delay line, token queue, ack flag) is compared against
//                the DUT every cycle; directed scenarios add literal checks.
//  Config      : HS4_SYNC3_EN changes the expected synchroniser depth.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hs4_rx_sync;

`ifdef HS4_SYNC3_EN
    localparam int NS = 3;
`else
    localparam int NS = 2;
`endif
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          cp = 1'b0;
    logic          cdn = 1'b0;
    logic          req = 1'b0;
    logic [DW-1:0] din = '0;
    logic          pop = 1'b0;
    logic          ack;
    logic [DW-1:0] dout;
    logic          dvalid;
    logic [AW:0]   count;

    int n_chk = 0;
    int n_err = 0;

    hs4_rx_sync #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .cp     (cp),
        .cdn    (cdn),
        .req    (req),
        .din    (din),
        .ack    (ack),
        .dout   (dout),
        .dvalid (dvalid),
        .pop    (pop),
        .count  (count)
    );

    always #5 cp = ~cp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NS-1:0] m_hist = '0;   // req as seen at the last NS edges, [0] newest
    int            m_since = 0;   // edges since reset released
    bit            m_ack = 0;
    bit            m_init = 0;
    logic [DW-1:0] m_q[$];

    always @(posedge cp) begin
        bit rs;
        int pre;
        if (!cdn) begin
            m_hist  = '0;
            m_since = 0;
            m_ack   = 0;
            m_q.delete();
            m_init  = 1;
        end else begin
            rs  = m_hist[NS-1];
            pre = m_q.size();
            if (m_since < 1000) m_since++;
            if (m_since == NS + 1) begin
                m_ack = rs;
            end else if (m_since > NS + 1) begin
                if (!m_ack && rs && pre < DEPTH) begin
                    m_q.push_back(din);
                    m_ack = 1;
                end else if (m_ack && !rs) begin
                    m_ack = 0;
                end
            end
            if (pop && pre > 0) void'(m_q.pop_front());
            m_hist = {m_hist[NS-2:0], req};
        end
    end

    // Compare DUT against the model away from the active edge
    always @(negedge cp) begin
        if (m_init) begin
            chk("ack", ack, m_ack);
            chk("count", count, m_q.size());
            chk("dvalid", dvalid, m_q.size() != 0);
            chk("dout", dout, (m_q.size() != 0) ? m_q[0] : 0);
        end
    end

    // Record every token the consumer takes during the stress run
    bit            rec = 0;
    logic [DW-1:0] got[$];
    always @(posedge cp) begin
        if (rec && cdn && pop && dvalid) got.push_back(dout);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge cp);
            #1;
        end
    endtask

    task automatic wait_ack(input logic val, input bit rp);
        for (int k = 0; k < 300 && ack !== val; k++) begin
            pop = rp ? ($urandom_range(0, 2) == 0) : 1'b0;
            tick(1);
        end
        pop = 1'b0;
        chk("wait_ack", ack, val);
    endtask

    task automatic send(input logic [DW-1:0] d, input bit rp);
        din = d;
        req = 1'b1;
        wait_ack(1'b1, rp);
        req = 1'b0;
        wait_ack(1'b0, rp);
    endtask

    initial begin
        // Reset state
        cdn = 1'b0;
        tick(3);
        chk("rst_ack", ack, 0);
        chk("rst_count", count, 0);
        chk("rst_dvalid", dvalid, 0);
        chk("rst_dout", dout, 0);
        cdn = 1'b1;
        tick(NS + 3);

        // 1: single token, latency NS+1 edges each phase
        din = 8'hA5;
        req = 1'b1;
        tick(NS);
        chk("t1_ack_early", ack, 0);
        tick(1);
        chk("t1_ack_rise", ack, 1);
        chk("t1_dvalid", dvalid, 1);
        chk("t1_dout", dout, 8'hA5);
        chk("t1_count", count, 1);
        req = 1'b0;
        tick(NS);
        chk("t1_ack_hold", ack, 1);
        tick(1);
        chk("t1_ack_fall", ack, 0);

        // 2: backpressure
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        chk("t2_full", count, 4);
        din = 8'h55;
        req = 1'b1;
        tick(20);
        chk("t2_bp_ack", ack, 0);
        chk("t2_bp_count", count, 4);
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        chk("t2_pop_count", count, 3);
        chk("t2_pop_ack", ack, 0);
        chk("t2_pop_dout", dout, 8'h11);
        tick(1);
        chk("t2_late_ack", ack, 1);
        chk("t2_refill", count, 4);
        req = 1'b0;
        wait_ack(1'b0, 0);

        // 3: pop on the capture edge at count=2
        pop = 1'b1;
        tick(2);
        pop = 1'b0;
        chk("t3_count2", count, 2);
        chk("t3_head", dout, 8'h33);
        din = 8'h77;
        req = 1'b1;
        tick(NS);
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        chk("t3_ack", ack, 1);
        chk("t3_count", count, 2);
        chk("t3_dout", dout, 8'h55);
        req = 1'b0;
        wait_ack(1'b0, 0);
        pop = 1'b1;
        tick(2);
        pop = 1'b0;
        chk("t3_drained", dvalid, 0);

        // 4: reset mid-handshake with req held high
        din = 8'h99;
        req = 1'b1;
        tick(NS + 1);
        chk("t4_pre_ack", ack, 1);
        cdn = 1'b0;
        tick(1);
        chk("t4_rst_ack", ack, 0);
        chk("t4_rst_count", count, 0);
        chk("t4_rst_dvalid", dvalid, 0);
        cdn = 1'b1;
        tick(NS + 1);
        chk("t4_stale_ack", ack, 1);
        chk("t4_no_capture", count, 0);
        req = 1'b0;
        wait_ack(1'b0, 0);
        send(8'h3C, 0);
        chk("t4_dout", dout, 8'h3C);
        chk("t4_count", count, 1);
        pop = 1'b1;
        tick(1);
        pop = 1'b0;

        // 6: stress, 64 tokens with random gaps and random pops
        rec = 1;
        for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, 4)) begin
                pop = ($urandom_range(0, 2) == 0);
                tick(1);
            end
            send(DW'(i), 1);
        end
        for (int k = 0; k < 50 && dvalid; k++) begin
            pop = 1'b1;
            tick(1);
        end
        pop = 1'b0;
        tick(1);
        rec = 0;
        chk("t6_total", got.size(), 64);
        for (int i = 0; i < got.size(); i++) begin
            chk("t6_order", got[i], i);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
